gate_identifier: RTL

- Sequential characteriser for two-input logic gates.
- Drives the four input combinations onto an external gate under test (GUT), waits a settle time for each, samples the GUT output, and assembles a 4-bit truth table.
- Decodes the truth table to one of AND/OR/NAND/NOR/XOR/XNOR, or flags it as unknown.
- Sits on the bench/board side of the team's basic gate logic as a self-checking front end.

---
 rtl/gate_id_defs.sv | 25 ++
 rtl/gate_decode.sv | 23 ++
 rtl/gate_identifier.sv | 84 ++++++++
 3 files changed

// File: rtl/gate_id_defs.sv
// Shared constants for the two-input gate characteriser:
// gate codes, reference truth tables and FSM state encodings.
package gate_id_defs;

    localparam logic [2:0] GC_UNKNOWN = 3'd0;
    localparam logic [2:0] GC_AND     = 3'd1;
    localparam logic [2:0] GC_OR      = 3'd2;
    localparam logic [2:0] GC_NAND    = 3'd3;
    localparam logic [2:0] GC_NOR     = 3'd4;
    localparam logic [2:0] GC_XOR     = 3'd5;
    localparam logic [2:0] GC_XNOR    = 3'd6;

    // Truth-table bit index is {A,B}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;

endpackage

// File: rtl/gate_decode.sv
// Combinational truth-table to gate-code decoder.
// Anything that is not one of the six reference tables decodes as unknown.
module gate_decode
    import gate_id_defs::*;
(
    input  logic [3:0] truth,
    output logic [2:0] code
);

    always_comb begin
        code = GC_UNKNOWN;
        case (truth)
            TT_AND:  code = GC_AND;
            TT_OR:   code = GC_OR;
            TT_NAND: code = GC_NAND;
            TT_NOR:  code = GC_NOR;
            TT_XOR:  code = GC_XOR;
            TT_XNOR: code = GC_XNOR;
            default: code = GC_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/gate_identifier.sv
// Sweeps the four {A,B} combinations through an external gate,
// samples its output after a settle time and publishes the decoded gate.
module gate_identifier
    import gate_id_defs::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic [2:0] gate_code,
    output logic       valid_match,
    output logic [3:0] truth
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES);

    logic [1:0]       state;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       scratch;
    logic [2:0]       code_next;

    gate_decode u_decode (
        .truth (scratch),
        .code  (code_next)
    );

    assign busy  = (state != ST_IDLE);
    assign a_out = (state == ST_DRIVE) && idx[1];
    assign b_out = (state == ST_DRIVE) && idx[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            cnt         <= '0;
            scratch     <= 4'd0;
            done        <= 1'b0;
            gate_code   <= GC_UNKNOWN;
            valid_match <= 1'b0;
            truth       <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_DRIVE;
                        idx   <= 2'd0;
                        cnt   <= RELOAD;
                    end
                end
                ST_DRIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        scratch[idx] <= y_in;
                        if (idx == 2'd3) begin
                            state <= ST_DECODE;
                        end else begin
                            idx <= idx + 2'd1;
                            cnt <= RELOAD;
                        end
                    end
                end
                ST_DECODE: begin
                    truth       <= scratch;
                    gate_code   <= code_next;
                    valid_match <= (code_next != GC_UNKNOWN);
                    done        <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
